// File: rtl/dac_tx_pkg.sv
// Shared types for the codec DAC serial transmit path.
package dac_tx_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAD,
        RSLOT
    } state_t;

endpackage

// File: rtl/lrc_edge_detect.sv
// Registers the codec frame clock and flags its rising and falling edges.
module lrc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic lrc,
    output logic rise,
    output logic fall
);

    logic lrc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lrc_q <= 1'b0;
        end else begin
            lrc_q <= lrc;
        end
    end

    assign rise = lrc & ~lrc_q;
    assign fall = ~lrc & lrc_q;

endmodule

// File: rtl/dac_stream_tx.sv
// Left-justified MSB-first sample serialiser toward the codec DAC (BCLK domain).
// Define DAC_TX_RIGHT_DUP_EN to repeat the left word in the right slot.
module dac_stream_tx
    import dac_tx_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  logic         bclk,
    input  logic         reset,
    input  logic         daclrc,
    input  logic         valid,
    input  logic [N-1:0] sample_data,
    output logic         ready,
    output logic         dacdat,
    output logic         underrun
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_N   = CW'(N);

    logic          lrc_rise;
    logic          lrc_fall;
    logic [N-1:0]  hold;
    logic          hold_full;
    logic          hold_full_nx;
    logic          accept;
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  shl;
    logic [CW-1:0] cnt;
    logic          right_msb;
    logic          right_bit;
    state_t        state;

    lrc_edge_detect u_lrc (
        .clk   (bclk),
        .reset (reset),
        .lrc   (daclrc),
        .rise  (lrc_rise),
        .fall  (lrc_fall)
    );

    assign accept       = valid & ready;
    assign hold_full_nx = accept | (hold_full & ~lrc_rise);
    assign shl          = shift_reg << cnt;

`ifdef DAC_TX_RIGHT_DUP_EN
    logic [N-1:0] copy_reg;
    logic [N-1:0] cshl;

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            copy_reg <= '0;
        end else if (lrc_rise) begin
            copy_reg <= hold_full ? hold : '0;
        end
    end

    assign cshl      = copy_reg << cnt;
    assign right_msb = copy_reg[N-1];
    assign right_bit = (cnt == CNT_N) ? 1'b0 : cshl[N-1];
`else
    assign right_msb = 1'b0;
    assign right_bit = 1'b0;
`endif

    // ready is registered so upstream never sees a path from valid
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
            ready     <= 1'b0;
        end else begin
            if (accept) begin
                hold <= sample_data;
            end
            hold_full <= hold_full_nx;
            ready     <= ~hold_full_nx;
        end
    end

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            dacdat    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (lrc_rise) begin
                state <= SHIFT;
                cnt   <= CNT_ONE;
                if (hold_full) begin
                    shift_reg <= hold;
                    dacdat    <= hold[N-1];
                end else begin
                    shift_reg <= '0;
                    dacdat    <= 1'b0;
                    underrun  <= 1'b1;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        dacdat <= 1'b0;
                    end
                    SHIFT: begin
                        if (lrc_fall) begin
                            state  <= RSLOT;
                            cnt    <= CNT_ONE;
                            dacdat <= right_msb;
                        end else if (cnt == CNT_N) begin
                            state  <= PAD;
                            dacdat <= 1'b0;
                        end else begin
                            dacdat <= shl[N-1];
                            cnt    <= cnt + CNT_ONE;
                        end
                    end
                    PAD: begin
                        if (lrc_fall) begin
                            state  <= RSLOT;
                            cnt    <= CNT_ONE;
                            dacdat <= right_msb;
                        end else begin
                            dacdat <= 1'b0;
                        end
                    end
                    RSLOT: begin
                        dacdat <= right_bit;
                        if (cnt != CNT_N) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dac_stream_tx.md
Name: dac_stream_tx

Overview:
- Left-justified, MSB-first serial transmitter toward the codec DAC: the playback counterpart of the mic capture path.
- Accepts parallel N-bit samples over a valid/ready handshake, buffers one sample, and serialises it onto DACDAT in the left-channel slot framed by codec-driven DACLRC.
- Runs entirely in the BCLK domain; the codec is frame master, and I2C has already configured it for LJ, N-bit.

Parameters:
- N, 16, sample width in bits; legal range 2..32.

Ports:
- bclk  in  1  codec bit clock; the only clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- daclrc  in  1  codec frame clock; high = left slot, low = right slot.
- valid  in  1  upstream sample valid.
- sample_data  in  N  upstream sample, two's complement.
- ready  out  1  block can accept a sample this cycle.
- dacdat  out  1  serial data to codec; registered output.
- underrun  out  1  one-cycle pulse when a left frame starts with no buffered sample.

Behaviour:
- Reset values: ready=0, dacdat=0, underrun=0, state=IDLE, hold_full=0, shift register=0, bit counter=0, daclrc_q=0.
- ready goes to 1 on the first bclk edge after reset deasserts.
- Edge detect:
  - daclrc_q registers daclrc.
  - lrc_rise = daclrc & ~daclrc_q.
  - lrc_fall = ~daclrc & daclrc_q.
- Holding register (one entry):
  - ready = ~hold_full, driven from a register with no combinational path from valid.
  - Accept when valid & ready: capture sample_data and set hold_full on that edge.
- Frame start, in any state, when lrc_rise=1:
  - If hold_full: move hold to shift_reg, clear hold_full, and drive dacdat <= hold[N-1] on the same edge.
  - If hold is empty: load shift_reg with 0, drive dacdat <= 0, and pulse underrun=1 for exactly one cycle.
  - In both cases set bit counter=1 and go to SHIFT.
- Simultaneous accept and lrc_rise with hold empty: the new sample goes to hold only and is sent in the next frame. The current frame underruns.
- Simultaneous lrc_rise and hold_full: ready is 0 that cycle. ready returns to 1 on the following edge.
- States:
  - IDLE: dacdat=0, waiting for lrc_rise.
  - SHIFT: each edge, dacdat <= shift_reg[(N-1)-cnt] and cnt <= cnt+1. When cnt==N, dacdat <= 0 and go to PAD.
  - PAD: dacdat=0 for the rest of the slot. lrc_fall -> RSLOT.
  - RSLOT: right-slot behaviour, see Optional Feature. lrc_rise -> new frame.
- Latency: MSB appears on dacdat at the edge where lrc_rise is seen, so the codec samples it on the next bclk rise. The LSB is driven N-1 edges later.
- Early frame: an lrc_rise during SHIFT, PAD or RSLOT aborts the current word and starts a new frame as above. No error flag is raised.
- An lrc_fall during SHIFT truncates the left word: go to RSLOT.
- Reset mid-word forces the reset values immediately, and the buffered sample is discarded.
- The bit counter is $clog2(N+1) bits wide and never wraps past N.

Optional Feature:
- Macro: DAC_TX_RIGHT_DUP_EN.
- Defined: a copy of the left word is kept. On lrc_fall the same word is retransmitted MSB-first in the right slot with identical timing, then dacdat=0. After an underrun frame the right slot is 0.
- Undefined: dacdat=0 throughout the right slot, and the copy register is not synthesised.

Decomposition:
- Package dac_tx_pkg: state_t enum {IDLE, SHIFT, PAD, RSLOT} and a localparam for the default width of 16.
- One natural sub-module, lrc_edge_detect: registered daclrc with rise/fall outputs. It is reusable by the capture path.
- The serialiser and holding register stay in the top module.

Test Plan:
- Load 16'hA5C3 before a frame, then lrc_rise -> dacdat over 16 edges = 1010_0101_1100_0011, then 0; underrun stays 0; ready returns to 1 one edge after the load.
- No sample offered, then lrc_rise -> dacdat all 0 for the frame; underrun is high exactly one cycle.
- valid held with 16'h0001 and 16'h8000 back-to-back -> first accepted, ready=0 until the next frame start. Frames transmit 0x0001 then 0x8000, with no loss or duplication.
- Reset asserted at bit 7 of 16'hFFFF -> dacdat=0, ready=0 asynchronously. After release, the next frame underruns.
- lrc_rise after only 5 bits of 16'h1234 with 16'h5678 buffered -> 0x5678 starts MSB-first at once.
- DAC_TX_RIGHT_DUP_EN defined, 16'h3C3C -> identical bit sequence in both slots. Undefined -> right slot all 0.
